multicycle_control: RTL and testbench

- Multi-cycle sequencer for the LEGv8 datapath.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath control lines per state.
- Handles the req/ready handshakes to instruction and data memory.
- Supports the same instruction set as the single-cycle decoder: AND/ORR/ADD/SUB reg, ADD/SUB imm, MOVZ, B, CBZ, LDUR, STUR.

---
 rtl/multicycle_control.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 control sequencer: FETCH/DECODE/EXEC/MEM/WB with imem/dmem handshakes.
// Optional macro ILLEGAL_OP_TRAP_EN: undefined opcodes halt instead of retiring as a NOP.
module multicycle_control #(
   parameter int OPW = 11
) (
   input  logic           CLK,
   input  logic           resetl,
   input  logic [OPW-1:0] opcode,
   input  logic           zero,
   input  logic           imem_ready,
   input  logic           dmem_ready,
   output logic           imem_req,
   output logic           dmem_req,
   output logic           irwrite,
   output logic           pcwrite,
   output logic           pcsrc,
   output logic           reg2loc,
   output logic           alusrc,
   output logic           mem2reg,
   output logic           regwrite,
   output logic           memread,
   output logic           memwrite,
   output logic [3:0]     aluop,
   output logic [2:0]     signop,
   output logic           retire,
   output logic           halted,
   output logic [2:0]     state_o
);

   typedef enum logic [2:0] {
      S_RST    = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_e;

   typedef enum logic [3:0] {
      C_ILL, C_AND, C_ORR, C_ADD, C_SUB, C_ADDI, C_SUBI,
      C_MOVZ, C_B, C_CBZ, C_LDUR, C_STUR
   } op_class_e;

`ifdef ILLEGAL_OP_TRAP_EN
   localparam bit TrapEn = 1'b1;
`else
   localparam bit TrapEn = 1'b0;
`endif

   function automatic op_class_e classify(input logic [OPW-1:0] op);
      op_class_e c;
      casez (op)
         11'b10001010000: c = C_AND;
         11'b10101010000: c = C_ORR;
         11'b10001011000: c = C_ADD;
         11'b11001011000: c = C_SUB;
         11'b1001000100?: c = C_ADDI;
         11'b1101000100?: c = C_SUBI;
         11'b110100101??: c = C_MOVZ;
         11'b000101?????: c = C_B;
         11'b10110100???: c = C_CBZ;
         11'b11111000010: c = C_LDUR;
         11'b11111000000: c = C_STUR;
         default:         c = C_ILL;
      endcase
      return c;
   endfunction

   state_e         state_q, state_d;
   logic [OPW-1:0] op_q, op_d;
   op_class_e      op_cls, dec_cls;

   // The IR is only valid from DECODE on; DECODE itself must look at the live opcode.
   assign dec_cls = classify(opcode);
   assign op_cls  = classify(op_q);
   assign state_o = state_q;

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         state_q <= S_RST;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
      end
   end

   always_comb begin
      // NOTE: every output gets a default first, so no path through the case can infer a latch.
      state_d  = state_q;
      op_d     = op_q;
      imem_req = 1'b0;
      dmem_req = 1'b0;
      irwrite  = 1'b0;
      pcwrite  = 1'b0;
      pcsrc    = 1'b0;
      reg2loc  = 1'b0;
      alusrc   = 1'b0;
      mem2reg  = 1'b0;
      regwrite = 1'b0;
      memread  = 1'b0;
      memwrite = 1'b0;
      aluop    = 4'b0000;
      signop   = 3'b000;
      retire   = 1'b0;
      halted   = 1'b0;

      unique case (state_q)
         S_RST: state_d = S_FETCH;

         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               irwrite = 1'b1;
               state_d = S_DECODE;
            end
         end

         S_DECODE: begin
            op_d    = opcode;
            reg2loc = (dec_cls == C_CBZ) || (dec_cls == C_STUR);
            state_d = (TrapEn && dec_cls == C_ILL) ? S_HALT : S_EXEC;
         end

         S_EXEC: begin
            state_d = S_WB;
            unique case (op_cls)
               C_AND:  aluop = 4'b0000;
               C_ORR:  aluop = 4'b0001;
               C_ADD:  aluop = 4'b0010;
               C_SUB:  aluop = 4'b0110;
               C_ADDI: begin aluop = 4'b0010; alusrc = 1'b1; end
               C_SUBI: begin aluop = 4'b0110; alusrc = 1'b1; end
               C_MOVZ: begin aluop = 4'b0111; alusrc = 1'b1; signop = 3'b100; end
               C_LDUR, C_STUR: begin
                  aluop   = 4'b0010;
                  alusrc  = 1'b1;
                  signop  = 3'b001;
                  state_d = S_MEM;
               end
               C_B: begin
                  signop  = 3'b010;
                  pcwrite = 1'b1;
                  pcsrc   = 1'b1;
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
               C_CBZ: begin
                  aluop   = 4'b0111;
                  signop  = 3'b011;
                  pcwrite = 1'b1;
                  pcsrc   = zero;
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
               default: ;  // undefined opcode passes through as a NOP
            endcase
         end

         S_MEM: begin
            dmem_req = 1'b1;
            memread  = (op_cls == C_LDUR);
            memwrite = (op_cls == C_STUR);
            if (dmem_ready) begin
               if (op_cls == C_STUR) begin
                  pcwrite = 1'b1;
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end
         end

         S_WB: begin
            regwrite = (op_cls != C_ILL);
            mem2reg  = (op_cls == C_LDUR);
            pcwrite  = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
         end

         S_HALT: halted = TrapEn;

         default: state_d = S_RST;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class cycle by cycle
// against hand-computed state and control vectors.
module tb_multicycle_control;

   logic        CLK = 1'b0;
   logic        resetl;
   logic [10:0] opcode;
   logic        zero, imem_ready, dmem_ready;
   logic        imem_req, dmem_req, irwrite, pcwrite, pcsrc, reg2loc, alusrc;
   logic        mem2reg, regwrite, memread, memwrite, retire, halted;
   logic [3:0]  aluop;
   logic [2:0]  signop, state_o;

   int n_checks = 0;
   int n_errors = 0;

   multicycle_control #(.OPW(11)) dut (
      .CLK(CLK), .resetl(resetl), .opcode(opcode), .zero(zero),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(imem_req), .dmem_req(dmem_req), .irwrite(irwrite),
      .pcwrite(pcwrite), .pcsrc(pcsrc), .reg2loc(reg2loc), .alusrc(alusrc),
      .mem2reg(mem2reg), .regwrite(regwrite), .memread(memread),
      .memwrite(memwrite), .aluop(aluop), .signop(signop), .retire(retire),
      .halted(halted), .state_o(state_o)
   );

   always #5 CLK = ~CLK;

   // Control bit positions in the packed observation vector.
   localparam logic [12:0] IREQ = 13'h1000, DREQ = 13'h0800, IRW  = 13'h0400,
                           PCW  = 13'h0200, PCS  = 13'h0100, R2L  = 13'h0080,
                           ASRC = 13'h0040, M2R  = 13'h0020, REGW = 13'h0010,
                           MRD  = 13'h0008, MWR  = 13'h0004, RET  = 13'h0002,
                           HLT  = 13'h0001;

   logic [12:0] ctl;
   assign ctl = {imem_req, dmem_req, irwrite, pcwrite, pcsrc, reg2loc, alusrc,
                 mem2reg, regwrite, memread, memwrite, retire, halted};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs are set by the caller just after a rising edge; this checks the cycle, then advances.
   task automatic cyc(input string tag, input logic [2:0] st, input logic [12:0] c,
                      input logic [3:0] a, input logic [2:0] s);
      #1;
      check({tag, " state"}, 32'(state_o), 32'(st));
      check({tag, " ctl"}, 32'(ctl), 32'(c));
      check({tag, " aluop/signop"}, 32'({aluop, signop}), 32'({a, s}));
      @(posedge CLK);
      #1;
   endtask

   logic [10:0] t_op [6]  = '{11'h450, 11'h550, 11'h658, 11'h488, 11'h689, 11'h697};
   logic [3:0]  t_alu [6] = '{4'b0000, 4'b0001, 4'b0110, 4'b0010, 4'b0110, 4'b0111};
   logic [2:0]  t_sgn [6] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100};
   logic        t_src [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

   initial begin
      resetl = 1'b0; opcode = '0; zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
      #12;
      check("reset state", 32'(state_o), 32'd0);
      check("reset ctl", 32'(ctl), 32'd0);
      @(negedge CLK);
      resetl = 1'b1;
      #1;
      check("rst after release", 32'(state_o), 32'd0);
      @(posedge CLK);
      #1;

      // ADD reg; stray dmem_ready and late imem_ready must be ignored
      imem_ready = 1'b1; dmem_ready = 1'b1; opcode = 11'h458;
      cyc("add fetch", 3'd1, IREQ | IRW, 4'b0000, 3'b000);
      imem_ready = 1'b0;
      cyc("add decode", 3'd2, '0, 4'b0000, 3'b000);
      imem_ready = 1'b1;
      cyc("add exec", 3'd3, '0, 4'b0010, 3'b000);
      imem_ready = 1'b0;
      cyc("add wb", 3'd5, REGW | PCW | RET, 4'b0000, 3'b000);

      // LDUR with two dmem wait cycles
      imem_ready = 1'b1; dmem_ready = 1'b0; opcode = 11'h7C2;
      cyc("ldur fetch", 3'd1, IREQ | IRW, 4'b0000, 3'b000);
      imem_ready = 1'b0;
      cyc("ldur decode", 3'd2, '0, 4'b0000, 3'b000);
      cyc("ldur exec", 3'd3, ASRC, 4'b0010, 3'b001);
      cyc("ldur mem w1", 3'd4, DREQ | MRD, 4'b0000, 3'b000);
      cyc("ldur mem w2", 3'd4, DREQ | MRD, 4'b0000, 3'b000);
      dmem_ready = 1'b1;
      cyc("ldur mem rdy", 3'd4, DREQ | MRD, 4'b0000, 3'b000);
      dmem_ready = 1'b0;
      cyc("ldur wb", 3'd5, REGW | M2R | PCW | RET, 4'b0000, 3'b000);

      // ALU register/immediate/MOVZ forms
      for (int i = 0; i < 6; i++) begin
         imem_ready = 1'b1; opcode = t_op[i];
         cyc($sformatf("alu%0d fetch", i), 3'd1, IREQ | IRW, 4'b0000, 3'b000);
         imem_ready = 1'b0;
         cyc($sformatf("alu%0d decode", i), 3'd2, '0, 4'b0000, 3'b000);
         cyc($sformatf("alu%0d exec", i), 3'd3, t_src[i] ? ASRC : 13'h0, t_alu[i], t_sgn[i]);
         cyc($sformatf("alu%0d wb", i), 3'd5, REGW | PCW | RET, 4'b0000, 3'b000);
      end

      // CBZ taken, then not taken
      for (int z = 1; z >= 0; z--) begin
         imem_ready = 1'b1; opcode = 11'h5A0; zero = 1'b0;
         cyc($sformatf("cbz%0d fetch", z), 3'd1, IREQ | IRW, 4'b0000, 3'b000);
         imem_ready = 1'b0;
         cyc($sformatf("cbz%0d decode", z), 3'd2, R2L, 4'b0000, 3'b000);
         zero = z[0];
         cyc($sformatf("cbz%0d exec", z), 3'd3, PCW | RET | (z == 1 ? PCS : 13'h0),
             4'b0111, 3'b011);
      end
      zero = 1'b0;

      // STUR with immediate dmem_ready
      imem_ready = 1'b1; opcode = 11'h7C0;
      cyc("stur fetch", 3'd1, IREQ | IRW, 4'b0000, 3'b000);
      imem_ready = 1'b0;
      cyc("stur decode", 3'd2, R2L, 4'b0000, 3'b000);
      cyc("stur exec", 3'd3, ASRC, 4'b0010, 3'b001);
      dmem_ready = 1'b1;
      cyc("stur mem", 3'd4, DREQ | MWR | PCW | RET, 4'b0000, 3'b000);
      dmem_ready = 1'b0;

      // B with one imem wait cycle
      imem_ready = 1'b0; opcode = 11'h0A0;
      cyc("b fetch wait", 3'd1, IREQ, 4'b0000, 3'b000);
      imem_ready = 1'b1;
      cyc("b fetch", 3'd1, IREQ | IRW, 4'b0000, 3'b000);
      imem_ready = 1'b0;
      cyc("b decode", 3'd2, '0, 4'b0000, 3'b000);
      cyc("b exec", 3'd3, PCW | PCS | RET, 4'b0000, 3'b010);

      // Reset pulsed while STUR waits in MEM
      imem_ready = 1'b1; opcode = 11'h7C0;
      cyc("rst-stur fetch", 3'd1, IREQ | IRW, 4'b0000, 3'b000);
      imem_ready = 1'b0;
      cyc("rst-stur decode", 3'd2, R2L, 4'b0000, 3'b000);
      cyc("rst-stur exec", 3'd3, ASRC, 4'b0010, 3'b001);
      #1;
      check("rst-stur mem ctl", 32'(ctl), 32'(DREQ | MWR));
      #1;
      resetl = 1'b0;
      #1;
      check("rst-stur async state", 32'(state_o), 32'd0);
      check("rst-stur async ctl", 32'(ctl), 32'd0);
      @(posedge CLK);
      #1;
      check("rst-stur held ctl", 32'(ctl), 32'd0);
      @(negedge CLK);
      resetl = 1'b1;
      @(posedge CLK);
      #1;

      // Undefined opcode
      imem_ready = 1'b1; opcode = 11'h000;
      cyc("ill fetch", 3'd1, IREQ | IRW, 4'b0000, 3'b000);
      imem_ready = 1'b0;
      cyc("ill decode", 3'd2, '0, 4'b0000, 3'b000);
`ifdef ILLEGAL_OP_TRAP_EN
      cyc("ill halt1", 3'd6, HLT, 4'b0000, 3'b000);
      imem_ready = 1'b1;
      cyc("ill halt2", 3'd6, HLT, 4'b0000, 3'b000);
      cyc("ill halt3", 3'd6, HLT, 4'b0000, 3'b000);
`else
      cyc("ill exec", 3'd3, '0, 4'b0000, 3'b000);
      cyc("ill wb", 3'd5, PCW | RET, 4'b0000, 3'b000);
      cyc("ill next fetch", 3'd1, IREQ, 4'b0000, 3'b000);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
